// File: rtl/edabk_uart_pkg.sv
// edabk_uart_pkg: shared UART line levels, default sizing, parity mode type and calc_parity helper
package edabk_uart_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CLK_DIV = 16;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
  typedef enum logic {PARITY_EVEN, PARITY_ODD} parity_mode_e;
  function automatic logic calc_parity(input logic [63:0] data, input parity_mode_e mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction
endpackage

// File: rtl/edabk_baud_tick_counter.sv
// edabk_baud_tick_counter: bit-period counter 0..CLK_DIV-1 while run, zeroed by restart/reset; tick_last flags the final cycle (ports bclk, reset, run, restart -> tick_last)
module edabk_baud_tick_counter #(
  parameter int CLK_DIV = 16
) (
  input  logic bclk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick_last
);
  localparam int TICK_WIDTH = $clog2(CLK_DIV);
  logic [TICK_WIDTH-1:0] tick_q, tick_d;
  assign tick_last = tick_q == TICK_WIDTH'(CLK_DIV - 1);
  always_comb tick_d = restart ? '0 : !run ? tick_q : tick_last ? '0 : tick_q + 1'b1;
  always_ff @(posedge bclk) tick_q <= reset ? '0 : tick_d;
endmodule

// File: rtl/edabk_transmitter_datapath.sv
// edabk_transmitter_datapath: UART frame serialiser (bclk, reset, data_in, parity_en, parity_odd, load, shift, clear -> tx, done, busy); EDABK_UART_TWO_STOP_BITS_EN adds a second stop bit
module edabk_transmitter_datapath
  import edabk_uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  clear,
  output logic                  tx,
  output logic                  done,
  output logic                  busy
);
`ifdef EDABK_UART_TWO_STOP_BITS_EN
  localparam int STOP_EXTRA = 1;
`else
  localparam int STOP_EXTRA = 0;
`endif
  localparam int FRAME_WIDTH = DATA_WIDTH + 3 + STOP_EXTRA;
  localparam int BL_WIDTH = $clog2(FRAME_WIDTH + 1);
  logic [FRAME_WIDTH-1:0] frame_q, frame_d, load_frame;
  logic [BL_WIDTH-1:0] bits_left_q, bits_left_d, load_bits;
  logic busy_q, busy_d, tx_q, tx_d, par, tick_last, do_shift;
  edabk_baud_tick_counter #(.CLK_DIV(CLK_DIV)) u_tick (
    .bclk     (bclk),
    .reset    (reset),
    .run      (busy_q),
    .restart  (load | clear),
    .tick_last(tick_last)
  );
  always_comb begin
    par = parity_en ? calc_parity(64'(data_in), parity_mode_e'(parity_odd)) : IDLE_LINE;
`ifdef EDABK_UART_TWO_STOP_BITS_EN
    load_frame = {STOP_BIT, STOP_BIT, par, data_in, START_BIT};
`else
    load_frame = {STOP_BIT, par, data_in, START_BIT};
`endif
    load_bits = BL_WIDTH'(DATA_WIDTH + 2 + STOP_EXTRA) + BL_WIDTH'(parity_en);
    do_shift = shift && busy_q;
    frame_d = load ? load_frame : clear ? '1 : do_shift ? {IDLE_LINE, frame_q[FRAME_WIDTH-1:1]} : frame_q;
    bits_left_d = load ? load_bits : clear ? '0 : do_shift ? bits_left_q - 1'b1 : bits_left_q;
    busy_d = load ? 1'b1 : clear ? 1'b0 : do_shift ? bits_left_q != BL_WIDTH'(1) : busy_q;
    tx_d = busy_d ? frame_d[0] : IDLE_LINE;
  end
  always_ff @(posedge bclk) begin
    if (reset) begin
      frame_q     <= '1;
      bits_left_q <= '0;
      busy_q      <= 1'b0;
      tx_q        <= IDLE_LINE;
    end else begin
      frame_q     <= frame_d;
      bits_left_q <= bits_left_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
    end
  end
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = busy_q && tick_last;
endmodule

// File: tb/tb_edabk_transmitter_datapath.sv
// tb_edabk_transmitter_datapath: scoreboard bench for the UART transmitter datapath
module tb_edabk_transmitter_datapath;
  localparam int DW = 8;
  localparam int DIV = 16;
`ifdef EDABK_UART_TWO_STOP_BITS_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif
  logic bclk = 1'b0, reset = 1'b1, parity_en = 1'b0, parity_odd = 1'b0;
  logic load = 1'b0, shift = 1'b0, clear = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic tx, done, busy;
  int n_cmp = 0, n_err = 0, mon_dones = 0, per_cnt = 0;
  logic exp_q[$];
  always #5 bclk = ~bclk;
  edabk_transmitter_datapath #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .bclk      (bclk),
    .reset     (reset),
    .data_in   (data_in),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .load      (load),
    .shift     (shift),
    .clear     (clear),
    .tx        (tx),
    .done      (done),
    .busy      (busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge bclk) begin
    if (busy) per_cnt++;
    else per_cnt = 0;
    if (!busy) chk("done_while_idle", done, 0);
    if (done) begin
      mon_dones++;
      chk("bit_period", per_cnt, DIV);
      per_cnt = 0;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done=1 with no bit outstanding, tx=%0b", tx);
      end else chk("tx_bit", tx, exp_q.pop_front());
    end
  end
  task automatic ctrl_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      shift = done;
      @(posedge bclk);
      #1 shift = 1'b0;
      @(negedge bclk);
    end
  endtask
  task automatic send(input logic [DW-1:0] d, input logic pen, input logic podd,
                      input logic [11:0] frame, input logic with_clear);
    int n;
    n = 10 + int'(pen) + XS;
    for (int i = 0; i < n; i++) exp_q.push_back(frame[i]);
    mon_dones = 0;
    data_in = d;
    parity_en = pen;
    parity_odd = podd;
    load = 1'b1;
    clear = with_clear;
    @(posedge bclk);
    #1 load = 1'b0;
    clear = 1'b0;
    data_in = ~d;
    parity_en = ~pen;
    parity_odd = ~podd;
    @(negedge bclk);
    chk("start_tx", tx, 0);
    chk("start_busy", busy, 1);
  endtask
  task automatic run_frame(input logic pen);
    int n, budget;
    n = 10 + int'(pen) + XS;
    budget = n * DIV + 20;
    while (busy && budget > 0) begin
      ctrl_cycles(1);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: busy still %0b after %0d cycles", busy, n * DIV + 20);
    end
    chk("frame_dones", mon_dones, n);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
  endtask
  task automatic frame(input logic [DW-1:0] d, input logic pen, input logic podd,
                       input logic [11:0] f, input logic with_clear);
    send(d, pen, podd, f, with_clear);
    run_frame(pen);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int budget;
    repeat (3) @(posedge bclk);
    @(negedge bclk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge bclk);
    frame(8'hA5, 1'b1, 1'b0, 12'b11_0_10100101_0, 1'b0);
    frame(8'hA5, 1'b1, 1'b1, 12'b11_1_10100101_0, 1'b0);
    frame(8'h00, 1'b1, 1'b0, 12'b11_0_00000000_0, 1'b0);
    frame(8'hA5, 1'b0, 1'b0, 12'b11_1_10100101_0, 1'b0);
    send(8'hA5, 1'b1, 1'b0, 12'b11_0_10100101_0, 1'b0);
    ctrl_cycles(39);
    reset = 1'b1;
    @(posedge bclk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge bclk);
    chk("mid_reset_tx", tx, 1);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_done", done, 0);
    mon_dones = 0;
    ctrl_cycles(40);
    chk("post_reset_dones", mon_dones, 0);
    send(8'hA5, 1'b1, 1'b0, 12'b11_0_10100101_0, 1'b0);
    budget = 5 * DIV;
    while (mon_dones < 4 && budget > 0) begin
      ctrl_cycles(1);
      budget--;
    end
    chk("reach_bit4_dones", mon_dones, 4);
    ctrl_cycles(5);
    chk("data3_tx_before_clear", tx, 0);
    clear = 1'b1;
    @(posedge bclk);
    #1 clear = 1'b0;
    exp_q.delete();
    @(negedge bclk);
    chk("clear_tx", tx, 1);
    chk("clear_busy", busy, 0);
    clear = 1'b1;
    ctrl_cycles(4);
    chk("clear_idle_tx", tx, 1);
    chk("clear_idle_busy", busy, 0);
    clear = 1'b0;
    frame(8'h3C, 1'b1, 1'b0, 12'b11_0_00111100_0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      shift = 1'b1;
      @(posedge bclk);
      #1;
      @(negedge bclk);
      chk("idle_shift_tx", tx, 1);
      chk("idle_shift_busy", busy, 0);
    end
    shift = 1'b0;
    frame(8'h81, 1'b1, 1'b1, 12'b11_1_10000001_0, 1'b1);
    frame(8'hFF, 1'b0, 1'b0, 12'b11_1_11111111_0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/edabk_transmitter_datapath.md
Name: edabk_transmitter_datapath

Overview:
- Serialising datapath directly downstream of the UART transmitter controller.
- Consumes the controller's load, shift and clear strobes and drives the serial tx line.
- Builds the frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, stop bit.
- Times each bit over CLK_DIV bclk cycles and pulses done back to the controller at the end of every bit period.

Parameters:
- DATA_WIDTH, 8 (`CFG_DATA_WIDTH): data bits per frame.
- CLK_DIV, 16 (`CFG_CLK_DIV): bclk cycles per serial bit; must be >= 2.
- FRAME_WIDTH, DATA_WIDTH+3 (+1 with optional feature): width of the frame shift register.
- TICK_WIDTH, $clog2(CLK_DIV): width of the bit-period counter.

Ports:
- bclk  in  1  baud clock; the only clock.
- reset  in  1  synchronous reset, active-high.
- data_in  in  DATA_WIDTH  parallel byte; sampled only when load=1.
- parity_en  in  1  1 = parity bit inserted; sampled on load.
- parity_odd  in  1  1 = odd parity, 0 = even; sampled on load.
- load  in  1  capture frame and start transmission.
- shift  in  1  advance to the next frame bit.
- clear  in  1  abort or idle: return to idle line.
- tx  out  1  serial output, registered.
- done  out  1  one-cycle pulse at the end of each bit period.
- busy  out  1  frame register holds untransmitted bits.

Behaviour:
- Reset (sync, reset=1 at posedge bclk) values: tx=1, done=0, busy=0, frame_reg=all 1s, tick=0, bits_left=0. Reset wins over every strobe, including mid-frame; the frame is dropped.
- Strobe priority per cycle: reset > load > clear > shift.
- Load: frame_reg <= {1 (stop), par, data_in, 0 (start)} when parity_en=1.
  - par = ^data_in when parity_odd=0; ~^data_in when parity_odd=1.
  - Without parity: frame_reg <= {1, 1, data_in, 0}; the spare bit is idle high.
  - bits_left <= DATA_WIDTH+2+parity_en; tick <= 0; busy <= 1.
  - tx goes 0 (start bit) on the cycle after load. Latency: load -> start bit = 1 bclk.
- Tick counter: counts 0..CLK_DIV-1 while busy=1, then wraps to 0.
  - done=1 combinationally for exactly the cycle where busy=1 and tick==CLK_DIV-1.
  - done is never asserted while busy=0.
- Shift: frame_reg <= {1, frame_reg[FRAME_WIDTH-1:1]}; bits_left decrements.
  - When bits_left is 1 before the shift, it becomes 0 and busy <= 0.
  - shift does not reset tick; the controller asserts shift in the done cycle, so bit boundaries stay aligned.
  - shift with busy=0 is ignored; frame_reg stays all 1s and bits_left stays 0 (no underflow).
- Clear: busy <= 0, tick <= 0, bits_left <= 0, frame_reg <= all 1s. tx returns high on the next cycle.
  - Clear held high in idle is the normal case and is harmless.
- tx = frame_reg[0] when busy=1, else 1. Registered; no combinational path from any input to tx.
- Load while busy=1: the current frame is discarded and the new frame starts immediately (controller never does this; defined for robustness).
- Load and clear in the same cycle: load wins.

Optional Feature:
- Macro: EDABK_UART_TWO_STOP_BITS_EN.
- Defined: FRAME_WIDTH = DATA_WIDTH+4; a second stop bit is appended and bits_left on load = DATA_WIDTH+3+parity_en.
- Undefined: single stop bit as above.
- Every other rule is unchanged in both builds.

Decomposition:
- Shared package edabk_uart_pkg:
  - localparams for the start/stop bit levels (START_BIT=0, STOP_BIT=1, IDLE_LINE=1).
  - Parity-mode typedef enum {PARITY_EVEN, PARITY_ODD}.
  - Function calc_parity(data, odd).
- One sub-module, edabk_baud_tick_counter (CLK_DIV): inputs bclk, reset, run, restart; output tick_last. Reused later by the receiver.

Test Plan:
1. DATA_WIDTH=8, CLK_DIV=16, load with data_in=0xA5, parity_en=1, parity_odd=0, shift on each done -> tx holds 0,1,0,1,0,0,1,0,1,0,1, 16 cycles per bit; 11 done pulses; busy falls after the 11th shift.
2. Same data with parity_odd=1 -> parity bit = 1. Data 0x00, even -> parity 0. parity_en=0 -> 10 bits, then tx=1.
3. Reset asserted at cycle 40 mid-frame -> next cycle tx=1, busy=0, done=0; no further done pulses.
4. Clear asserted during data bit 3 -> tx=1 next cycle, busy=0; a subsequent load transmits a full fresh frame correctly.
5. shift pulses with busy=0, and load+clear in the same cycle -> no tx change while idle; load wins and the start bit appears.
6. EDABK_UART_TWO_STOP_BITS_EN defined, 0xFF without parity -> 11 bit periods; last two tx bits = 1; 11 done pulses.
